regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//   Read-side companion to the 16x16 regfile: on a start pulse, walks a register
//   range through one regfile read port and streams each (addr, data) beat out
//   over a valid/ready handshake to a debug sink (UART/VGA/bench monitor).
//   Sits beside the datapath and shares regfile read port 1 via the top-level mux.
// PARAMETERS
//   DATA_WIDTH  16  register width
//   ADDR_WIDTH  4   register address width; NUM_REGS = 2**ADDR_WIDTH
// PORTS
//   clk        in   1           single system clock, rising edge
//   reset      in   1           asynchronous, active-high reset
//   start      in   1           begin dump; sampled only in IDLE
//   first_addr in   ADDR_WIDTH  first register of range, latched on start
//   last_addr  in   ADDR_WIDTH  last register of range (inclusive), latched on start
//   ra         out  ADDR_WIDTH  regfile read address
//   rd         in   DATA_WIDTH  regfile read data (combinational w.r.t. ra)
//   out_valid  out  1           beat valid
//   out_ready  in   1           sink accepts beat
//   out_addr   out  ADDR_WIDTH  register index of beat
//   out_data   out  DATA_WIDTH  register contents of beat
//   out_last   out  1           final beat of dump
//   out_sum    out  1           beat is checksum (only with macro; else tied 0)
//   busy       out  1           high from cycle after start through DONE
//   done       out  1           one-cycle pulse after final beat accepted
// BEHAVIOUR
//   - Reset: state=IDLE; ra, out_addr, out_data, idx, count = 0; out_valid,
//     out_last, out_sum, busy, done = 0. Reset mid-dump abandons it; no beat completes.
//   - FSM IDLE -> READ -> SEND -> (READ | SUM | DONE) -> IDLE.
//   - IDLE: start=1 latches idx=first_addr, remaining=((last-first) mod NUM_REGS)+1.
//   - READ (1 cycle): ra=idx; at edge capture out_data<=rd, out_addr<=idx,
//     out_last<=(remaining==1 && no checksum), out_valid<=1.
//   - SEND: all out_* held stable while out_valid && !out_ready. On handshake:
//     out_valid<=0; if remaining>1: idx<=idx+1 (mod NUM_REGS wrap), remaining--, ->READ;
//     else ->SUM (macro) or DONE.
//   - DONE: done=1 for exactly one cycle, busy=0 on next cycle, ->IDLE.
//   - Latency: start edge -> out_valid high 2 cycles later; with out_ready held 1,
//     one beat every 2 cycles.
//   - first_addr>last_addr wraps 15->0 (e.g. 14..1 = 14,15,0,1). first==last = one beat.
//   - start while busy ignored; first/last changes after latch ignored.
//   - ra holds last value outside READ; the top-level mux grants the port only while busy.
// CONFIGURATION
//   REGFILE_DUMP_CHECKSUM_EN defined: running XOR of every dumped out_data; after
//     last register, SUM state emits one extra beat out_data=XOR, out_addr=0,
//     out_sum=1, out_last=1 (register beats then never assert out_last).
//   Undefined: no SUM state, no accumulator, out_sum tied 0, last register beat
//     carries out_last=1.
// STRUCTURE
//   Shared package/include: state encodings (ST_IDLE, ST_READ, ST_SEND, ST_SUM,
//     ST_DONE), DATA_WIDTH/ADDR_WIDTH defaults shared with regfile and alu.
//   Single flat module; no sub-module warranted (FSM + counter + output regs).
// TESTING
//   1. Preload r1=0x000A, r2=0x07FF; first=1,last=2, out_ready=1 -> beats
//      (1,0x000A,last=0),(2,0x07FF,last=1); done pulse once; busy low after.
//   2. first=14,last=1, regs=0x0E0E,0x0F0F,0x1111,0x2222 -> 4 beats addr 14,15,0,1 in order.
//   3. out_ready low 5 cycles during beat 1 -> out_addr/out_data/out_valid stable,
//      single accept, no duplicated or skipped register.
//   4. start pulsed again mid-dump with other range -> ignored; original range completes.
//   5. reset asserted during SEND -> out_valid, busy, done drop asynchronously; next
//      start dumps cleanly from new first_addr.
//   6. Macro on, r1=0xFFFF,r2=0x5FBD dumped -> extra beat out_sum=1, out_data=0xA042,
//      out_last=1; register beats out_last=0.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the regfile dump reader: default widths common with
// the regfile/alu, and the dump FSM state encoding.
package regfile_dump_reader_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_SUM,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping register range through one regfile read port and streams
// (addr, data) beats over valid/ready. Optional XOR checksum beat: REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_sum,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CHECKSUM = 1'b1;
`else
  localparam bit CHECKSUM = 1'b0;
`endif

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [ADDR_WIDTH-1:0] span;
  logic                  sum_beat;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  out_sum_q, out_sum_d;
  assign sum_beat = out_sum_q;
  assign out_sum  = out_sum_q;
`else
  assign sum_beat = 1'b0;
  assign out_sum  = 1'b0;
`endif

  // Modular difference gives the wrapped range length minus one.
  assign span = last_addr - first_addr;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    sum_d       = sum_q;
    out_sum_d   = out_sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = first_addr;
          rem_d   = CNT_W'(span) + CNT_W'(1);
          state_d = ST_READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_READ: begin
        out_data_d  = rd;
        out_addr_d  = idx_q;
        out_last_d  = (rem_q == CNT_W'(1)) && !CHECKSUM;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        sum_d       = sum_q ^ rd;
        out_sum_d   = 1'b0;
`endif
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (sum_beat) begin
            state_d = ST_DONE;
          end else if (rem_q > CNT_W'(1)) begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            rem_d   = rem_q - CNT_W'(1);
            state_d = ST_READ;
          end else begin
            state_d = CHECKSUM ? ST_SUM : ST_DONE;
          end
        end
      end
      ST_SUM: begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_data_d  = sum_q;
        out_addr_d  = '0;
        out_last_d  = 1'b1;
        out_sum_d   = 1'b1;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
`else
        state_d     = ST_DONE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q     <= '0;
      out_sum_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      out_sum_q <= out_sum_d;
    end
  end
`endif

  // idx only moves on the edge into READ, so it doubles as the held read address.
  assign ra        = idx_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader; a bench-side regfile array answers ra.
module tb_regfile_dump_reader;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  first_addr, last_addr, ra, out_addr;
  logic [15:0] rd, out_data;
  logic        out_valid, out_ready, out_last, out_sum, busy, done;
  logic [15:0] regs [16];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    int         n;
    logic [3:0] end_a;
    int         stall;
    bit         restart;
  } vec_t;

  vec_t vecs [6];

  regfile_dump_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .ra(ra), .rd(rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_last(out_last), .out_sum(out_sum), .busy(busy), .done(done)
  );

  assign rd = regs[ra];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int exp_n,
                          input logic [3:0] exp_end, input int stall, input bit restart,
                          output logic [15:0] sum_seen);
    int n, sums, guard, stall_left;
    bit seen_done, glitched;
    logic [3:0] a, last_a;
    logic [15:0] x;
    n = 0; sums = 0; guard = 0; stall_left = stall;
    seen_done = 0; glitched = 0; last_a = '0; x = '0; sum_seen = '0;
    @(negedge clk);
    out_ready = (stall == 0);
    start = 1'b1; first_addr = f; last_addr = l;
    @(negedge clk);
    start = 1'b0; first_addr = ~f; last_addr = ~l;
    check("busy_after_start", 32'(busy), 32'd1);
    check("valid_latency", 32'(out_valid), 32'd0);
    while (!seen_done && guard < 200) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (restart && n == 1 && !glitched) begin
        start = 1'b1; first_addr = 4'd9; last_addr = 4'd11; glitched = 1;
      end
      if (done) begin
        seen_done = 1;
      end else if (out_valid) begin
        a = f + n[3:0];
        if (!out_ready) begin
          check("stall_addr", 32'(out_addr), 32'(a));
          check("stall_data", 32'(out_data), 32'(regs[a]));
          stall_left--;
          if (stall_left <= 0) out_ready = 1'b1;
        end
        if (out_ready) begin
          if (out_sum) begin
            check("sum_addr", 32'(out_addr), 32'd0);
            check("sum_data", 32'(out_data), 32'(x));
            check("sum_last", 32'(out_last), 32'd1);
            sum_seen = out_data;
            sums++;
          end else begin
            check("beat_addr", 32'(out_addr), 32'(a));
            check("beat_data", 32'(out_data), 32'(regs[a]));
            check("beat_last", 32'(out_last), (!CK && n == exp_n - 1) ? 32'd1 : 32'd0);
            x = x ^ regs[a];
            last_a = out_addr;
            n++;
          end
        end
      end
    end
    check("done_seen", 32'(seen_done), 32'd1);
    check("beat_count", 32'(n), 32'(exp_n));
    check("end_addr", 32'(last_a), 32'(exp_end));
    check("sum_beats", 32'(sums), 32'(CK));
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] s;
    reset = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b0;
    for (int unsigned i = 0; i < 16; i++) regs[i] = 16'(i * 32'h1357 + 32'h0101);

    vecs[0] = '{f: 4'd4,  l: 4'd4,  n: 1,  end_a: 4'd4,  stall: 0, restart: 0};
    vecs[1] = '{f: 4'd0,  l: 4'd15, n: 16, end_a: 4'd15, stall: 0, restart: 0};
    vecs[2] = '{f: 4'd3,  l: 4'd6,  n: 4,  end_a: 4'd6,  stall: 5, restart: 0};
    vecs[3] = '{f: 4'd7,  l: 4'd9,  n: 3,  end_a: 4'd9,  stall: 0, restart: 1};
    vecs[4] = '{f: 4'd15, l: 4'd0,  n: 2,  end_a: 4'd0,  stall: 0, restart: 0};
    vecs[5] = '{f: 4'd5,  l: 4'd4,  n: 16, end_a: 4'd4,  stall: 0, restart: 0};

    repeat (2) @(negedge clk);
    check("rst_ra", 32'(ra), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    regs[1] = 16'h000A; regs[2] = 16'h07FF;
    run_dump(4'd1, 4'd2, 2, 4'd2, 0, 0, s);

    regs[14] = 16'h0E0E; regs[15] = 16'h0F0F; regs[0] = 16'h1111; regs[1] = 16'h2222;
    run_dump(4'd14, 4'd1, 4, 4'd1, 0, 0, s);

    for (int i = 0; i < 6; i++)
      run_dump(vecs[i].f, vecs[i].l, vecs[i].n, vecs[i].end_a, vecs[i].stall, vecs[i].restart, s);

    // Asynchronous reset while a beat is stalled in SEND.
    @(negedge clk);
    out_ready = 1'b0; start = 1'b1; first_addr = 4'd3; last_addr = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_addr", 32'(out_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", 32'(out_valid | busy), 32'd0);
    end
    run_dump(4'd5, 4'd6, 2, 4'd6, 0, 0, s);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    regs[1] = 16'hFFFF; regs[2] = 16'h5FBD;
    run_dump(4'd1, 4'd2, 2, 4'd2, 0, 0, s);
    check("checksum_value", 32'(s), 32'h0000A042);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
